attack_query_sched: RTL and testbench
=====================================

Name: attack_query_sched

Overview:
- Scheduler that shares one single-square attack evaluator between two requesters.
- Requesters are the legality checker (port 0) and the castling-path checker (port 1).
- Each request carries a board, an attacker side and a 64-bit square mask. The block arbitrates between requesters, walks the set mask bits, issues one evaluator query per square, and collects a per-square attacked map plus an any-attacked summary.
- It sits between the move-generation logic and the evaluator bank. The bank is selected by square index and accepts board, side, valid and returns attacked, attacked_valid.

Parameters:
- PIECE_WIDTH, 4, bits per square piece code.
- BOARD_WIDTH, 256, total board bits; must equal PIECE_WIDTH*64. Square s occupies bits [s*PIECE_WIDTH +: PIECE_WIDTH], s = row*8+col.
- EVAL_TIMEOUT, 16, maximum cycles from ev_valid to attacked_valid before the query is abandoned (minimum 2).

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; combinational, at most one bit set
- req_board0 / req_board1  in  BOARD_WIDTH each  board per requester
- req_attacker  in  2  per-requester attacker side, 0=white 1=black
- req_mask0 / req_mask1  in  64 each  squares to test
- req_early_exit  in  2  per-requester: stop at first attacked square
- ev_board  out  BOARD_WIDTH  latched board to evaluator
- ev_attacker  out  1  latched side
- ev_square  out  6  square index under test
- ev_valid  out  1  one-cycle query strobe
- attacked  in  1  evaluator result
- attacked_valid  in  1  evaluator result strobe
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester that owns the response
- rsp_map  out  64  bit s set = square s attacked
- rsp_any  out  1  OR of rsp_map
- rsp_timeout  out  1  at least one query timed out

Behaviour:
- Reset values:
  - State IDLE; RR pointer favours port 0.
  - req_ready=0, ev_valid=0, ev_square=0, ev_board=0, ev_attacker=0.
  - rsp_valid=0, rsp_id=0, rsp_map=0, rsp_any=0, rsp_timeout=0.
  - Reset mid-operation aborts the query. Any late attacked_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration:
  - Round-robin grant: if both are valid, grant the port not granted last; otherwise grant whichever is valid.
  - req_ready[g] = (state==IDLE) && req_valid[g]. A request is accepted in the cycle that req_valid & req_ready are both high.
  - On accept, latch board, side, mask (working copy), early_exit and id. Clear the map and timeout flag. Update the RR pointer.
  - Next state is ISSUE, or DONE if the mask is zero.
- ISSUE:
  - ev_valid=1 for exactly one cycle.
  - ev_square = lowest set bit of the working mask (ascending scan order).
  - Clear that bit in the working copy. Load the timeout counter. Go to WAIT.
- WAIT, on attacked_valid:
  - rsp_map[ev_square] <= attacked.
  - If attacked && early_exit, or the working mask is now zero, go to DONE. Otherwise go to ISSUE.
- WAIT, on counter reaching EVAL_TIMEOUT without attacked_valid:
  - Treat the square as attacked (conservative) and set rsp_timeout.
  - Apply the same next-state rule as a normal result.
- Stray results: attacked_valid outside WAIT is ignored.
- DONE:
  - rsp_valid=1; rsp_any = |rsp_map.
  - Response outputs are stable while rsp_valid && !rsp_ready.
  - On rsp_ready, return to IDLE the next cycle. No request is accepted in DONE.
- Latency, with evaluator latency L cycles (ev_valid at S, attacked_valid at S+L):
  - Accept at T; first ev_valid at T+1; successive ev_valid strobes are L+1 apart.
  - rsp_valid at T+1+k(L+1) for k squares evaluated.
  - Empty mask: rsp_valid at T+1.
  - Back-to-back requests: the next accept is possible in the cycle after the rsp handshake.
- ev_board and ev_attacker are held constant from accept until the next accept.
- Full mask (all 64 bits) scans squares 0..63 and ends after square 63; no wrap.

Test Plan:
- Port 0, mask=0x0000_0000_0000_0010 (square 4), evaluator L=3 returns attacked=1 -> one ev_valid, ev_square=4 at T+1; rsp_valid at T+5; rsp_map=0x10, rsp_any=1, rsp_id=0.
- Port 1, mask=0x60 (squares 5,6), early_exit=0, results 0 then 0 -> ev_square 5 then 6; rsp_map=0, rsp_any=0, rsp_id=1.
- Mask=0xF0, early_exit=1, square 5 returns attacked=1 -> squares 4,5 only; rsp_map=0x20, no query to squares 6 or 7.
- Both ports valid every cycle for 4 requests, after reset -> grants in order 0,1,0,1; req_ready never has both bits high.
- Evaluator silent on square 12, EVAL_TIMEOUT=16 -> abandoned 16 cycles after ev_valid; rsp_map bit 12=1, rsp_timeout=1; a late attacked_valid is ignored.
- Mask=0, then hold rsp_ready=0 for 5 cycles -> rsp_valid at T+1 and held with map=0; reset asserted mid-WAIT on a later query -> all outputs back to reset values next cycle.

Source files
------------

// File: rtl/attack_query_sched.sv
// ----------------------------------------------------------------------------
// attack_query_sched
//
// Shares one single-square attack evaluator between two requesters: the
// legality checker (port 0) and the castling-path checker (port 1).
// A request carries a board, an attacker side and a 64-bit square mask. The
// block arbitrates round-robin between the ports, walks the set mask bits in
// ascending order, issues one evaluator query per square and collects a
// per-square attacked map plus an any-attacked summary. A query that gets no
// answer within EVAL_TIMEOUT cycles is abandoned and the square is reported
// as attacked (conservative), with rsp_timeout raised.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid[1:0]      per-requester request valid
//   req_ready[1:0]      per-requester accept (combinational, one-hot or zero)
//   req_board0/1        board per requester
//   req_attacker[1:0]   per-requester attacker side (0 white, 1 black)
//   req_mask0/1         squares to test per requester
//   req_early_exit[1:0] per-requester: stop at first attacked square
//   ev_board            latched board to evaluator bank
//   ev_attacker         latched attacker side
//   ev_square           square index under test
//   ev_valid            one-cycle query strobe
//   attacked            evaluator result
//   attacked_valid      evaluator result strobe
//   rsp_valid/rsp_ready response handshake (rsp_valid held until accepted)
//   rsp_id              requester owning the response
//   rsp_map             bit s set = square s attacked
//   rsp_any             OR of rsp_map
//   rsp_timeout         at least one query was abandoned
// ----------------------------------------------------------------------------
module attack_query_sched #(
    parameter int unsigned PIECE_WIDTH  = 4,
    parameter int unsigned BOARD_WIDTH  = 256,
    parameter int unsigned EVAL_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [BOARD_WIDTH-1:0] req_board0,
    input  logic [BOARD_WIDTH-1:0] req_board1,
    input  logic [1:0]             req_attacker,
    input  logic [63:0]            req_mask0,
    input  logic [63:0]            req_mask1,
    input  logic [1:0]             req_early_exit,
    output logic [BOARD_WIDTH-1:0] ev_board,
    output logic                   ev_attacker,
    output logic [5:0]             ev_square,
    output logic                   ev_valid,
    input  logic                   attacked,
    input  logic                   attacked_valid,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [63:0]            rsp_map,
    output logic                   rsp_any,
    output logic                   rsp_timeout
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if (BOARD_WIDTH != PIECE_WIDTH * 64) begin : g_bad_board_width
        $error("attack_query_sched: BOARD_WIDTH must equal PIECE_WIDTH*64");
    end
    if (EVAL_TIMEOUT < 2) begin : g_bad_timeout
        $error("attack_query_sched: EVAL_TIMEOUT must be at least 2");
    end

    localparam int unsigned CNT_W = $clog2(EVAL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_last_grant;
    logic [BOARD_WIDTH-1:0] r_board;
    logic                   r_attacker;
    logic [63:0]            r_mask;
    logic                   r_early;
    logic                   r_id;
    logic [63:0]            r_map;
    logic                   r_timeout;
    logic [5:0]             r_square;
    logic [CNT_W-1:0]       r_cnt;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic                   w_grant;
    logic                   w_accept;
    logic [63:0]            w_req_mask;
    logic [BOARD_WIDTH-1:0] w_req_board;
    logic                   w_tmo_hit;
    logic                   w_result_valid;
    logic                   w_result;
    logic                   w_finish;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [5:0] f_lowest(input logic [63:0] m);
        logic [5:0] idx;
        idx = '0;
        for (int unsigned i = 64; i > 0; i--) begin
            if (m[i-1]) begin
                idx = 6'(i - 1);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------------
    // Arbitration: round-robin when both ports request, otherwise whichever
    // port is valid. Only the granted port sees req_ready, and only in IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant   = (&req_valid) ? ~r_last_grant : req_valid[1];
        w_accept  = (r_state == S_IDLE) && (|req_valid);
        req_ready = '0;
        req_ready[w_grant] = w_accept;
        w_req_mask  = w_grant ? req_mask1  : req_mask0;
        w_req_board = w_grant ? req_board1 : req_board0;
    end

    // ------------------------------------------------------------------------
    // Result qualification. A real result wins over a timeout landing in the
    // same cycle. An abandoned query counts as attacked.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tmo_hit      = (r_state == S_WAIT) && !attacked_valid &&
                         (r_cnt == CNT_W'(EVAL_TIMEOUT));
        w_result_valid = ((r_state == S_WAIT) && attacked_valid) || w_tmo_hit;
        w_result       = attacked_valid ? attacked : 1'b1;
        // r_mask already has the current square cleared while in WAIT.
        w_finish       = (w_result && r_early) || (r_mask == '0);
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and strobe outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ev_valid    = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_req_mask == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                ev_valid    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_result_valid) begin
                    w_state_nxt = w_finish ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. r_square is loaded with the next square one cycle ahead of
    // ISSUE, so ev_square is already valid during the ev_valid strobe and
    // stays stable through WAIT, where the result is written back.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_board      <= '0;
            r_attacker   <= 1'b0;
            r_mask       <= '0;
            r_early      <= 1'b0;
            r_id         <= 1'b0;
            r_map        <= '0;
            r_timeout    <= 1'b0;
            r_square     <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_board      <= w_req_board;
                        r_attacker   <= req_attacker[w_grant];
                        r_mask       <= w_req_mask;
                        r_early      <= req_early_exit[w_grant];
                        r_id         <= w_grant;
                        r_map        <= '0;
                        r_timeout    <= 1'b0;
                        r_last_grant <= w_grant;
                        r_square     <= f_lowest(w_req_mask);
                    end
                end
                S_ISSUE: begin
                    r_mask[r_square] <= 1'b0;
                    r_cnt            <= CNT_W'(1);
                end
                S_WAIT: begin
                    if (w_result_valid) begin
                        r_map[r_square] <= w_result;
                        if (w_tmo_hit) begin
                            r_timeout <= 1'b1;
                        end
                        if (!w_finish) begin
                            r_square <= f_lowest(r_mask);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ev_board    = r_board;
    assign ev_attacker = r_attacker;
    assign ev_square   = r_square;
    assign rsp_id      = r_id;
    assign rsp_map     = r_map;
    assign rsp_any     = |r_map;
    assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_attack_query_sched.sv
// ----------------------------------------------------------------------------
// tb_attack_query_sched
//
// Self-checking bench for attack_query_sched. An evaluator model answers each
// ev_valid after a configurable latency from a per-square truth map (or stays
// silent on one square). A reference model walks the request mask square by
// square to predict the queried squares, their strobe cycles, the response
// map, summary, timeout flag and response cycle.
// ----------------------------------------------------------------------------
module tb_attack_query_sched;

    localparam int unsigned PW  = 4;
    localparam int unsigned BW  = 256;
    localparam int          TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [BW-1:0] req_board0;
    logic [BW-1:0] req_board1;
    logic [1:0]    req_attacker;
    logic [63:0]   req_mask0;
    logic [63:0]   req_mask1;
    logic [1:0]    req_early_exit;
    logic [BW-1:0] ev_board;
    logic          ev_attacker;
    logic [5:0]    ev_square;
    logic          ev_valid;
    logic          attacked;
    logic          attacked_valid;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [63:0]   rsp_map;
    logic          rsp_any;
    logic          rsp_timeout;

    attack_query_sched #(
        .PIECE_WIDTH (PW),
        .BOARD_WIDTH (BW),
        .EVAL_TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_board0    (req_board0),
        .req_board1    (req_board1),
        .req_attacker  (req_attacker),
        .req_mask0     (req_mask0),
        .req_mask1     (req_mask1),
        .req_early_exit(req_early_exit),
        .ev_board      (ev_board),
        .ev_attacker   (ev_attacker),
        .ev_square     (ev_square),
        .ev_valid      (ev_valid),
        .attacked      (attacked),
        .attacked_valid(attacked_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_map       (rsp_map),
        .rsp_any       (rsp_any),
        .rsp_timeout   (rsp_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Evaluator model
    // ------------------------------------------------------------------------
    int          ev_lat    = 1;
    logic [63:0] ev_truth  = '0;
    int          ev_silent = -1;
    int          ev_stray  = 1000000;
    int          log_sq[$];
    int          log_cyc[$];
    int          q_due[$];
    logic        q_val[$];

    initial begin : evaluator
        int idx;
        attacked       = 1'b0;
        attacked_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (ev_valid === 1'b1) begin
                log_sq.push_back(int'(ev_square));
                log_cyc.push_back(cyc);
                if (int'(ev_square) == ev_silent) begin
                    q_due.push_back(cyc + ev_stray);
                    q_val.push_back(1'b0);
                end else begin
                    q_due.push_back(cyc + ev_lat);
                    q_val.push_back(ev_truth[ev_square]);
                end
            end
            @(posedge clk);
            #1;
            attacked_valid = 1'b0;
            attacked       = 1'b0;
            idx = -1;
            foreach (q_due[i]) if (q_due[i] == cyc) idx = i;
            if (idx >= 0) begin
                attacked_valid = 1'b1;
                attacked       = q_val[idx];
                q_due.delete(idx);
                q_val.delete(idx);
            end
        end
    end

    // ------------------------------------------------------------------------
    // One request through the block, checked against the reference model.
    // ------------------------------------------------------------------------
    task automatic run_txn(input string name, input int port, input logic [63:0] mask,
                           input bit early, input int lat, input logic [63:0] truth,
                           input int silent, input int stray, input int hold);
        logic [63:0]   emap;
        bit            etmo;
        int            esq[$];
        int            ecyc[$];
        int            t;
        int            tacc;
        int            trsp;
        logic [BW-1:0] b0;
        logic [BW-1:0] b1;
        logic [1:0]    side;
        bit            ok;
        logic          r;

        emap = '0;
        etmo = 1'b0;
        for (int s = 0; s < 64; s++) begin
            if (mask[s]) begin
                r = (s == silent) ? 1'b1 : truth[s];
                emap[s] = r;
                esq.push_back(s);
                if (s == silent) etmo = 1'b1;
                if (r && early) break;
            end
        end

        ev_lat    = lat;
        ev_truth  = truth;
        ev_silent = silent;
        ev_stray  = stray;
        log_sq.delete();
        log_cyc.delete();
        b0   = rand_board();
        b1   = rand_board();
        side = 2'($urandom);

        @(posedge clk);
        #1;
        req_board0     = b0;
        req_board1     = b1;
        req_attacker   = side;
        req_mask0      = (port == 0) ? mask : rand64();
        req_mask1      = (port == 1) ? mask : rand64();
        req_early_exit = 2'($urandom);
        req_early_exit[port] = early;
        req_valid      = '0;
        req_valid[port] = 1'b1;

        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[port] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, ".accept"}, 256'(ok), 256'(1));
        if (!ok) begin
            req_valid = '0;
            return;
        end
        chk({name, ".ready"}, 256'(req_ready), (port == 0) ? 256'(2'b01) : 256'(2'b10));
        tacc = cyc;
        @(posedge clk);
        #1;
        req_valid = '0;

        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, ".rsp_seen"}, 256'(ok), 256'(1));
        if (!ok) return;
        trsp = cyc;

        t = tacc + 1;
        foreach (esq[j]) begin
            ecyc.push_back(t);
            t += ((esq[j] == silent) ? TMO : lat) + 1;
        end
        chk({name, ".rsp_cycle"}, 256'(trsp - tacc), 256'(t - tacc));
        chk({name, ".nqueries"}, 256'(log_sq.size()), 256'(esq.size()));
        foreach (esq[j]) begin
            if (j < log_sq.size()) begin
                chk($sformatf("%s.sq%0d", name, j), 256'(log_sq[j]), 256'(esq[j]));
                chk($sformatf("%s.evcyc%0d", name, j), 256'(log_cyc[j] - tacc), 256'(ecyc[j] - tacc));
            end
        end
        chk({name, ".rsp_id"}, 256'(rsp_id), 256'(port));
        chk({name, ".rsp_map"}, 256'(rsp_map), 256'(emap));
        chk({name, ".rsp_any"}, 256'(rsp_any), 256'(emap != '0));
        chk({name, ".rsp_timeout"}, 256'(rsp_timeout), 256'(etmo));
        chk({name, ".ev_board"}, 256'(ev_board), (port == 0) ? 256'(b0) : 256'(b1));
        chk({name, ".ev_attacker"}, 256'(ev_attacker), 256'(side[port]));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, ".hold_valid"}, 256'(rsp_valid), 256'(1));
            chk({name, ".hold_map"}, 256'(rsp_map), 256'(emap));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({name, ".hs_valid"}, 256'(rsp_valid), 256'(1));
        chk({name, ".hs_timeout"}, 256'(rsp_timeout), 256'(etmo));
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({name, ".released"}, 256'(rsp_valid), 256'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q_due.delete();
        q_val.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".ev_valid"}, 256'(ev_valid), 256'(0));
        chk({name, ".ev_square"}, 256'(ev_square), 256'(0));
        chk({name, ".ev_board"}, 256'(ev_board), 256'(0));
        chk({name, ".ev_attacker"}, 256'(ev_attacker), 256'(0));
        chk({name, ".rsp_valid"}, 256'(rsp_valid), 256'(0));
        chk({name, ".rsp_id"}, 256'(rsp_id), 256'(0));
        chk({name, ".rsp_map"}, 256'(rsp_map), 256'(0));
        chk({name, ".rsp_any"}, 256'(rsp_any), 256'(0));
        chk({name, ".rsp_timeout"}, 256'(rsp_timeout), 256'(0));
    endtask

    // ------------------------------------------------------------------------
    // Arbitration with both ports requesting continuously.
    // ------------------------------------------------------------------------
    task automatic run_arbitration();
        int   gnt[$];
        int   gcyc[$];
        int   both;
        int   last;
        int   exp_g;
        logic [63:0] fill;

        fill = 64'h0000_0000_0000_0010;
        both = 0;
        @(posedge clk);
        #1;
        req_mask0      = '0;
        req_mask1      = '0;
        req_board0     = rand_board();
        req_board1     = rand_board();
        req_attacker   = 2'($urandom);
        req_early_exit = '0;
        req_valid      = 2'b11;
        rsp_ready      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready === 2'b11) both++;
            if (req_ready != 2'b00) begin
                gnt.push_back(int'(req_ready[1]));
                gcyc.push_back(cyc);
            end
            if (gnt.size() == 4) break;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        chk("arb.both_ready", 256'(both), 256'(0));
        chk("arb.ngrants", 256'(gnt.size()), 256'(4));
        last = 1;
        foreach (gnt[k]) begin
            exp_g = 1 - last;
            last  = exp_g;
            chk($sformatf("arb.grant%0d", k), 256'(gnt[k]), 256'(exp_g));
            if (k > 0) chk($sformatf("arb.spacing%0d", k), 256'(gcyc[k] - gcyc[k-1]), 256'(2));
        end
        chk("arb.idle_after", 256'(rsp_valid), 256'(fill == '0));
    endtask

    // ------------------------------------------------------------------------
    // Reset asserted while a query is outstanding.
    // ------------------------------------------------------------------------
    task automatic run_reset_mid_wait();
        bit ok;
        int extra_ev;
        int extra_rsp;

        ev_lat    = 10;
        ev_truth  = '1;
        ev_silent = -1;
        @(posedge clk);
        #1;
        req_board0     = rand_board();
        req_board1     = rand_board();
        req_attacker   = 2'b11;
        req_mask0      = '0;
        req_mask1      = 64'h0000_0000_0000_0200;
        req_early_exit = '0;
        req_valid      = 2'b10;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[1] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("rstw.accept", 256'(ok), 256'(1));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ev_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstw.ev_seen", 256'(ok), 256'(1));
        chk("rstw.ev_square", 256'(ev_square), 256'(9));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstw.ready", 256'(req_ready), 256'(0));
        chk_reset_outputs("rstw");

        extra_ev  = 0;
        extra_rsp = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ev_valid === 1'b1) extra_ev++;
            if (rsp_valid === 1'b1) extra_rsp++;
        end
        chk("rstw.late_ev", 256'(extra_ev), 256'(0));
        chk("rstw.late_rsp", 256'(extra_rsp), 256'(0));
        chk("rstw.late_map", 256'(rsp_map), 256'(0));
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        logic [63:0] m;
        int          port;
        int          kind;
        int          sil;

        reset          = 1'b1;
        req_valid      = '0;
        req_board0     = '0;
        req_board1     = '0;
        req_attacker   = '0;
        req_mask0      = '0;
        req_mask1      = '0;
        req_early_exit = '0;
        rsp_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset.ready", 256'(req_ready), 256'(0));
        chk_reset_outputs("reset");

        run_txn("sq4", 0, 64'h10, 1'b0, 3, 64'h10, -1, 1000000, 0);
        run_txn("sq56", 1, 64'h60, 1'b0, 2, 64'h0, -1, 1000000, 0);
        run_txn("early", 0, 64'hF0, 1'b1, 2, 64'hE0, -1, 1000000, 0);

        do_reset();
        run_arbitration();

        run_txn("silent12", 0, 64'h1000, 1'b0, 2, 64'h0, 12, 19, 6);
        repeat (6) @(negedge clk);
        q_due.delete();
        q_val.delete();

        run_txn("empty", 1, 64'h0, 1'b0, 1, 64'h0, -1, 1000000, 5);
        run_txn("full", 0, '1, 1'b0, 1, rand64(), -1, 1000000, 0);

        run_reset_mid_wait();
        q_due.delete();
        q_val.delete();

        for (int n = 0; n < 30; n++) begin
            port = int'($urandom_range(1, 0));
            kind = int'($urandom_range(3, 0));
            case (kind)
                0:       m = '0;
                1:       m = 64'h1 << $urandom_range(63, 0);
                2:       m = rand64() & rand64() & rand64();
                default: m = rand64();
            endcase
            sil = -1;
            if (m != '0 && $urandom_range(4, 0) == 0) begin
                for (int s = 0; s < 64; s++) if (m[s] && sil < 0) sil = s;
            end
            run_txn($sformatf("rnd%0d", n), port, m, 1'($urandom), int'($urandom_range(4, 1)),
                    rand64(), sil, 1000000, int'($urandom_range(3, 0)));
            q_due.delete();
            q_val.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
